ft600_rx_packer: RTL and testbench



---
 rtl/ft600_rx_packer.sv | 176 +++++++++++++++++
 tb/tb_ft600_rx_packer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft600_rx_packer.sv
// FT600 receive packer: packs byte-enabled 16-bit words into 16-byte blocks with keep mask.
// Optional block statistics outputs are enabled by defining FT600_PACK_STATS_EN.
module ft600_rx_packer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic         ftdi_clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [15:0]  in_data,
    input  logic [1:0]   in_be,
    output logic         in_ready,
    input  logic         flush,
    output logic         out_valid,
    output logic [127:0] out_data,
    output logic [15:0]  out_keep,
    input  logic         out_ready
`ifdef FT600_PACK_STATS_EN
    ,
    output logic [31:0]  stat_blocks,
    output logic [15:0]  stat_partials
`endif
);

    localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] IDLE_CAP   = TIMEOUT_EN ? 16'(TIMEOUT_CYCLES) : 16'd0;

    logic [127:0] acc_q, acc_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [15:0]  idle_q, idle_d;
    logic         pend_q, pend_d;
    logic [127:0] out_data_q, out_data_d;
    logic [15:0]  out_keep_q, out_keep_d;
    logic         out_valid_q, out_valid_d;

    logic         out_free;
    logic         in_ready_c;
    logic         accept;
    logic [1:0]   n;
    logic [7:0]   b_first, b_second;
    logic [7:0]   pos0, pos1;
    logic [135:0] acc_ext;
    logic [4:0]   total;
    logic         timeout_hit;
    logic         req;
    logic [15:0]  keep_part;
    logic         emitted;

    always_comb begin
        out_free   = !out_valid_q || out_ready;
        in_ready_c = (cnt_q <= 4'd13) || out_free;
        accept     = in_valid && in_ready_c;

        b_first  = '0;
        b_second = '0;
        n        = 2'd0;
        if (accept) begin
            case (in_be)
                2'b01: begin
                    b_first = in_data[7:0];
                    n       = 2'd1;
                end
                2'b10: begin
                    b_first = in_data[15:8];
                    n       = 2'd1;
                end
                2'b11: begin
                    b_first  = in_data[7:0];
                    b_second = in_data[15:8];
                    n        = 2'd2;
                end
                default: n = 2'd0;
            endcase
        end

        // Bytes above cnt are always zero, so appending is a pure overwrite
        // and a partial block needs no extra masking of its unused bytes.
        pos0    = {1'b0, cnt_q, 3'b000};
        pos1    = pos0 + 8'd8;
        acc_ext = {8'h00, acc_q};
        if (n != 2'd0) acc_ext[pos0 +: 8] = b_first;
        if (n == 2'd2) acc_ext[pos1 +: 8] = b_second;
        total = {1'b0, cnt_q} + {3'b000, n};

        timeout_hit = TIMEOUT_EN && (idle_q == IDLE_CAP);
        req         = pend_q || flush || timeout_hit;
        keep_part   = 16'hFFFF >> (5'd16 - total);

        acc_d       = acc_ext[127:0];
        cnt_d       = total[3:0];
        pend_d      = req && (total != 5'd0);
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_valid_d = out_valid_q && !out_ready;
        emitted     = 1'b0;

        if (total >= 5'd16) begin
            // Full block; a byte landing at position 16 spills into the fresh accumulator.
            out_data_d  = acc_ext[127:0];
            out_keep_d  = 16'hFFFF;
            out_valid_d = 1'b1;
            acc_d       = {120'd0, acc_ext[135:128]};
            cnt_d       = total[3:0];
            pend_d      = req && (total[3:0] != 4'd0);
            emitted     = 1'b1;
        end else if (req && (total != 5'd0) && out_free) begin
            out_data_d  = acc_ext[127:0];
            out_keep_d  = keep_part;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = 4'd0;
            pend_d      = 1'b0;
            emitted     = 1'b1;
        end

        if (accept || emitted || (cnt_q == 4'd0)) begin
            idle_d = '0;
        end else if (idle_q != IDLE_CAP) begin
            idle_d = idle_q + 16'd1;
        end else begin
            idle_d = idle_q;
        end
    end

    always_ff @(posedge ftdi_clk) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            idle_q      <= '0;
            pend_q      <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            idle_q      <= idle_d;
            pend_q      <= pend_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_c;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;

`ifdef FT600_PACK_STATS_EN
    logic [31:0] stat_blocks_q, stat_blocks_d;
    logic [15:0] stat_partials_q, stat_partials_d;

    always_comb begin
        stat_blocks_d   = stat_blocks_q;
        stat_partials_d = stat_partials_q;
        if (out_valid_q && out_ready) begin
            stat_blocks_d = stat_blocks_q + 32'd1;
            if (out_keep_q != 16'hFFFF) stat_partials_d = stat_partials_q + 16'd1;
        end
    end

    always_ff @(posedge ftdi_clk) begin
        if (rst) begin
            stat_blocks_q   <= '0;
            stat_partials_q <= '0;
        end else begin
            stat_blocks_q   <= stat_blocks_d;
            stat_partials_q <= stat_partials_d;
        end
    end

    assign stat_blocks   = stat_blocks_q;
    assign stat_partials = stat_partials_q;
`endif

endmodule

// File: tb/tb_ft600_rx_packer.sv
// Bench for ft600_rx_packer: byte-queue reference model checked every cycle plus directed literal checks.
module tb_ft600_rx_packer;

    localparam int unsigned T = 20;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [15:0]  in_data = '0;
    logic [1:0]   in_be = '0;
    logic         in_ready;
    logic         flush = 1'b0;
    logic         out_valid;
    logic [127:0] out_data;
    logic [15:0]  out_keep;
    logic         out_ready = 1'b1;
`ifdef FT600_PACK_STATS_EN
    logic [31:0]  stat_blocks;
    logic [15:0]  stat_partials;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    ft600_rx_packer #(.TIMEOUT_CYCLES(T)) dut (
        .ftdi_clk  (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_be     (in_be),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_ready (out_ready)
`ifdef FT600_PACK_STATS_EN
        ,
        .stat_blocks   (stat_blocks),
        .stat_partials (stat_partials)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bytes queue in arrival order, blocks cut from its head.
    logic [7:0]   mq[$];
    bit           mvalid = 1'b0;
    logic [127:0] mdata  = '0;
    logic [15:0]  mkeep  = '0;
    int unsigned  idle   = 0;
    bit           mpend  = 1'b0;
    logic [31:0]  mstat_b = '0;
    logic [15:0]  mstat_p = '0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete();
                mvalid = 1'b0; mdata = '0; mkeep = '0;
                idle = 0; mpend = 1'b0; mstat_b = '0; mstat_p = '0;
            end else begin
                int  pre;
                bit  free, rdy, acc_w, hit, req, emitted;
                pre   = mq.size();
                free  = !mvalid || out_ready;
                rdy   = (pre <= 13) || free;
                acc_w = in_valid && rdy;
                if (mvalid && out_ready) begin
                    mvalid = 1'b0;
                    mstat_b++;
                    if (mkeep != 16'hFFFF) mstat_p++;
                end
                hit = (T > 0) && (idle >= T);
                req = mpend || flush || hit;
                if (acc_w) begin
                    if (in_be[0]) mq.push_back(in_data[7:0]);
                    if (in_be[1]) mq.push_back(in_data[15:8]);
                end
                emitted = 1'b0;
                if (mq.size() >= 16) begin
                    for (int k = 0; k < 16; k++) mdata[8*k +: 8] = mq.pop_front();
                    mkeep = 16'hFFFF; mvalid = 1'b1; emitted = 1'b1;
                    mpend = req && (mq.size() > 0);
                end else if (req && (mq.size() > 0) && free) begin
                    int cnt;
                    cnt = mq.size();
                    mdata = '0; mkeep = '0;
                    for (int k = 0; k < cnt; k++) begin
                        mdata[8*k +: 8] = mq.pop_front();
                        mkeep[k] = 1'b1;
                    end
                    mvalid = 1'b1; emitted = 1'b1; mpend = 1'b0;
                end else begin
                    mpend = req && (mq.size() > 0);
                end
                if (acc_w || emitted || pre == 0) idle = 0;
                else if (idle < T) idle++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit exp_rdy;
            exp_rdy = (mq.size() <= 13) || !mvalid || out_ready;
            chk("model_out_valid", {127'd0, out_valid}, {127'd0, mvalid});
            chk("model_in_ready", {127'd0, in_ready}, {127'd0, exp_rdy});
            if (mvalid) begin
                chk("model_out_data", out_data, mdata);
                chk("model_out_keep", {112'd0, out_keep}, {112'd0, mkeep});
            end
`ifdef FT600_PACK_STATS_EN
            chk("model_stat_blocks", {96'd0, stat_blocks}, {96'd0, mstat_b});
            chk("model_stat_partials", {112'd0, stat_partials}, {112'd0, mstat_p});
`endif
        end
    end

    // Called at posedge+1; returns at posedge+1 after the edge that accepted the word.
    task automatic send(input logic [1:0] be, input logic [15:0] d);
        bit done = 1'b0;
        int waited = 0;
        in_valid = 1'b1; in_be = be; in_data = d;
        while (!done) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk); #1;
            if (!done) begin
                waited++;
                if (waited > 300) begin
                    n_tests++; n_fail++;
                    $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
                    done = 1'b1;
                end
            end
        end
        in_valid = 1'b0; in_be = '0; in_data = '0;
    endtask

    task automatic send_words(input logic [7:0] base, input int nw);
        for (int j = 0; j < nw; j++) begin
            logic [7:0] lo, hi;
            lo = base + 8'(2*j);
            hi = base + 8'(2*j + 1);
            send(2'b11, {hi, lo});
        end
    endtask

    task automatic wait_block(input string name, input logic [127:0] d, input logic [15:0] k,
                              input int budget);
        bit seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            seen = out_valid;
        end
        if (!seen) begin
            n_tests++; n_fail++;
            $display("FAIL %s_timeout: out_valid=0 after %0d cycles, required 1", name, budget);
        end else begin
            chk({name, "_data"}, out_data, d);
            chk({name, "_keep"}, {112'd0, out_keep}, {112'd0, k});
        end
        @(posedge clk); #1;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        chk("reset_out_valid", {127'd0, out_valid}, 128'd0);
        chk("reset_out_data", out_data, 128'd0);
        chk("reset_out_keep", {112'd0, out_keep}, 128'd0);
        chk("reset_in_ready", {127'd0, in_ready}, 128'd1);

        // Full words, latency one edge after the 8th accept
        send_words(8'h00, 8);
        chk("full_latency", {127'd0, out_valid}, 128'd1);
        wait_block("full", 128'h0F0E0D0C0B0A09080706050403020100, 16'hFFFF, 4);

        // Odd-byte spill then idle timeout
        send(2'b01, 16'h00AA);
        send_words(8'h00, 8);
        wait_block("spill", 128'h0E0D0C0B0A09080706050403020100AA, 16'hFFFF, 4);
        wait_block("timeout", 128'h0F, 16'h0001, T + 10);

        // Backpressure
        out_ready = 1'b0;
        fork
            send_words(8'h10, 16);
            begin
                repeat (22) @(negedge clk);
                chk("bp_hold_data_a", out_data, 128'h1F1E1D1C1B1A19181716151413121110);
                repeat (6) @(negedge clk);
                chk("bp_in_ready_low", {127'd0, in_ready}, 128'd0);
                chk("bp_out_valid", {127'd0, out_valid}, 128'd1);
                chk("bp_hold_data_b", out_data, 128'h1F1E1D1C1B1A19181716151413121110);
                chk("bp_hold_keep", {112'd0, out_keep}, {112'd0, 16'hFFFF});
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        wait_block("bp_second", 128'h2F2E2D2C2B2A29282726252423222120, 16'hFFFF, 4);

        // Flush of a partial block, then flush with nothing pending
        send_words(8'h30, 3);
        pulse_flush();
        wait_block("flush", 128'h353433323130, 16'h003F, 4);
        pulse_flush();
        repeat (5) @(negedge clk);
        chk("flush_empty_no_output", {127'd0, out_valid}, 128'd0);
        @(posedge clk); #1;

        // be=10 / be=00 / be=01 mix
        send(2'b10, 16'hBB00);
        send(2'b00, 16'h0000);
        send(2'b01, 16'h00CC);
        pulse_flush();
        wait_block("be_mix", 128'hCCBB, 16'h0003, 4);

        // Reset mid-block
        send_words(8'h40, 5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("midrst_in_ready", {127'd0, in_ready}, 128'd1);
`ifdef FT600_PACK_STATS_EN
        chk("midrst_stat_blocks", {96'd0, stat_blocks}, 128'd0);
        chk("midrst_stat_partials", {112'd0, stat_partials}, 128'd0);
`endif
        send_words(8'h50, 8);
        wait_block("midrst_clean", 128'h5F5E5D5C5B5A59585756555453525150, 16'hFFFF, 4);

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
